// File: rtl/craps_game_ctrl.sv
// craps_game_ctrl: game-rule engine for the craps datapath.
// Watches the debounced roll button for a rising edge. It samples both dice,
// applies the come-out and point rules, and drives the one-hot
// win/lose/roll result to the downstream encoder.
// Optional build macro: CRAPS_ROLL_COUNT_EN adds an 8-bit saturating
// roll_count output that counts accepted rolls of the current game.
module craps_game_ctrl #(
   parameter int DIE_W = 3,
   parameter int SUM_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             roll_req,
   input  logic [DIE_W-1:0] x0,
   input  logic [DIE_W-1:0] x1,
   output logic             win,
   output logic             lose,
   output logic             roll,
   output logic [SUM_W-1:0] point,
   output logic [SUM_W-1:0] last_sum,
`ifdef CRAPS_ROLL_COUNT_EN
   output logic [7:0]       roll_count,
`endif
   output logic             dice_err
);

   typedef enum logic [1:0] {
      COME_OUT = 2'd0,
      POINT    = 2'd1,
      DONE     = 2'd2
   } state_t;

   localparam logic [DIE_W-1:0] DIE_MAX = DIE_W'(6);
   localparam logic [SUM_W-1:0] SUM_2   = SUM_W'(2);
   localparam logic [SUM_W-1:0] SUM_3   = SUM_W'(3);
   localparam logic [SUM_W-1:0] SUM_7   = SUM_W'(7);
   localparam logic [SUM_W-1:0] SUM_11  = SUM_W'(11);
   localparam logic [SUM_W-1:0] SUM_12  = SUM_W'(12);

   state_t           state_q, state_d;
   logic             win_q, win_d;
   logic             lose_q, lose_d;
   logic             roll_q, roll_d;
   logic [SUM_W-1:0] point_q, point_d;
   logic [SUM_W-1:0] last_sum_q, last_sum_d;
   logic             dice_err_q, dice_err_d;
   logic             roll_req_q, roll_req_d;
   logic             armed_q, armed_d;
`ifdef CRAPS_ROLL_COUNT_EN
   logic [7:0]       count_q, count_d;
`endif

   logic             roll_ev;
   logic             dice_ok;
   logic [SUM_W-1:0] sum;

   // Roll event detection and dice qualification. The armed flag stays low
   // after reset until the button is seen released, so a button already held
   // when reset drops is not mistaken for a fresh press.
   always_comb begin
      roll_ev = roll_req & ~roll_req_q & armed_q;
      dice_ok = (x0 != '0) && (x0 <= DIE_MAX) && (x1 != '0) && (x1 <= DIE_MAX);
      sum     = SUM_W'(x0) + SUM_W'(x1);
   end

   // Next-state and next-output evaluation of the game rules. A roll from
   // DONE starts a new game and is judged by come-out rules in the same
   // cycle, so the first roll of a new game is never lost.
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      lose_d     = lose_q;
      roll_d     = roll_q;
      point_d    = point_q;
      last_sum_d = last_sum_q;
      dice_err_d = 1'b0;
      roll_req_d = roll_req;
      armed_d    = armed_q | ~roll_req;
`ifdef CRAPS_ROLL_COUNT_EN
      count_d    = count_q;
`endif
      if (roll_ev) begin
         if (!dice_ok) begin
            dice_err_d = 1'b1;
         end else begin
            last_sum_d = sum;
            if (state_q == POINT) begin
`ifdef CRAPS_ROLL_COUNT_EN
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
`endif
               if (sum == point_q) begin
                  win_d   = 1'b1;
                  lose_d  = 1'b0;
                  roll_d  = 1'b0;
                  state_d = DONE;
               end else if (sum == SUM_7) begin
                  win_d   = 1'b0;
                  lose_d  = 1'b1;
                  roll_d  = 1'b0;
                  state_d = DONE;
               end
            end else begin
`ifdef CRAPS_ROLL_COUNT_EN
               if (state_q == DONE) begin
                  count_d = 8'd1;
               end else begin
                  count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
               end
`endif
               point_d = '0;
               win_d   = 1'b0;
               lose_d  = 1'b0;
               roll_d  = 1'b0;
               if ((sum == SUM_7) || (sum == SUM_11)) begin
                  win_d   = 1'b1;
                  state_d = DONE;
               end else if ((sum == SUM_2) || (sum == SUM_3) || (sum == SUM_12)) begin
                  lose_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  point_d = sum;
                  roll_d  = 1'b1;
                  state_d = POINT;
               end
            end
         end
      end
   end

   // State and output registers; synchronous reset wins over any roll.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= COME_OUT;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
         roll_q     <= 1'b0;
         point_q    <= '0;
         last_sum_q <= '0;
         dice_err_q <= 1'b0;
         roll_req_q <= 1'b0;
         armed_q    <= 1'b0;
`ifdef CRAPS_ROLL_COUNT_EN
         count_q    <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
         roll_q     <= roll_d;
         point_q    <= point_d;
         last_sum_q <= last_sum_d;
         dice_err_q <= dice_err_d;
         roll_req_q <= roll_req_d;
         armed_q    <= armed_d;
`ifdef CRAPS_ROLL_COUNT_EN
         count_q    <= count_d;
`endif
      end
   end

   assign win      = win_q;
   assign lose     = lose_q;
   assign roll     = roll_q;
   assign point    = point_q;
   assign last_sum = last_sum_q;
   assign dice_err = dice_err_q;
`ifdef CRAPS_ROLL_COUNT_EN
   assign roll_count = count_q;
`endif

endmodule

// File: tb/tb_craps_game_ctrl.sv
// tb_craps_game_ctrl: self-checking bench for craps_game_ctrl.
// A rule-level model of the game tracks the expected outputs; directed
// scenarios are followed by a randomized roll sequence.
module tb_craps_game_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       roll_req = 1'b0;
   logic [2:0] x0 = 3'd1;
   logic [2:0] x1 = 3'd1;
   logic       win, lose, roll, dice_err;
   logic [3:0] point, last_sum;
`ifdef CRAPS_ROLL_COUNT_EN
   logic [7:0] roll_count;
`endif

   int assertCount = 0;
   int failCount = 0;

   // Reference model, kept in terms of the game: is a point on, is the game over
   bit mWin, mLose, mRoll, mErr, mInPoint, mOver;
   int mPoint, mLast, mCount;

   craps_game_ctrl #(.DIE_W(3), .SUM_W(4)) dut (
      .clock(clock),
      .reset(reset),
      .roll_req(roll_req),
      .x0(x0),
      .x1(x1),
      .win(win),
      .lose(lose),
      .roll(roll),
      .point(point),
      .last_sum(last_sum),
`ifdef CRAPS_ROLL_COUNT_EN
      .roll_count(roll_count),
`endif
      .dice_err(dice_err)
   );

   // Free-running clock
   always #5 clock = ~clock;

   wire [11:0] obsVec = {win, lose, roll, point, last_sum, dice_err};

   function automatic logic [11:0] expVec();
      return {mWin, mLose, mRoll, 4'(mPoint), 4'(mLast), mErr};
   endfunction

   function automatic void modelReset();
      mWin = 0; mLose = 0; mRoll = 0; mErr = 0;
      mInPoint = 0; mOver = 0; mPoint = 0; mLast = 0; mCount = 0;
   endfunction

   function automatic void modelRoll(input int a, input int b);
      int s;
      if (a < 1 || a > 6 || b < 1 || b > 6) begin
         mErr = 1;
         return;
      end
      s = a + b;
      mLast = s;
      if (!mInPoint && mOver) mCount = 0;
      mCount = (mCount < 255) ? mCount + 1 : 255;
      if (mInPoint) begin
         if (s == mPoint) begin
            mWin = 1; mRoll = 0; mInPoint = 0; mOver = 1;
         end else if (s == 7) begin
            mLose = 1; mRoll = 0; mInPoint = 0; mOver = 1;
         end
      end else begin
         mOver = 0; mPoint = 0; mWin = 0; mLose = 0; mRoll = 0;
         if (s == 7 || s == 11) begin
            mWin = 1; mOver = 1;
         end else if (s == 2 || s == 3 || s == 12) begin
            mLose = 1; mOver = 1;
         end else begin
            mPoint = s; mRoll = 1; mInPoint = 1;
         end
      end
   endfunction

   // Drivers: every task starts and ends just after a negedge
   task automatic press(input int a, input int b);
      x0 = 3'(a);
      x1 = 3'(b);
      roll_req = 1'b1;
      @(negedge clock);
      modelRoll(a, b);
   endtask

   task automatic holdBtn();
      @(negedge clock);
      mErr = 0;
   endtask

   task automatic releaseBtn();
      roll_req = 1'b0;
      @(negedge clock);
      mErr = 0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      roll_req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      modelReset();
      @(negedge clock);
   endtask

   task automatic test_reset();
      doReset();
      assertCount++;
      if (obsVec !== 12'b0) begin
         failCount++;
         $display("[TB] FAIL reset_state: {w,l,r,pt,sum,err} got %b expected %b", obsVec, 12'b0);
      end
`ifdef CRAPS_ROLL_COUNT_EN
      assertCount++;
      if (roll_count !== 8'd0) begin
         failCount++;
         $display("[TB] FAIL reset_count: got %0d expected 0", roll_count);
      end
`endif
   endtask

   task automatic test_come_out();
      int d[6] = '{3, 4, 1, 1, 5, 6};
      doReset();
      for (int i = 0; i < 6; i += 2) begin
         if (i == 2) doReset();
         press(d[i], d[i+1]);
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL come_out_%0d_%0d: got %b expected %b", d[i], d[i+1], obsVec, expVec());
         end
         releaseBtn();
      end
   endtask

   task automatic test_point();
      int d[10] = '{2, 2, 3, 3, 1, 3, 4, 5, 3, 4};
      for (int i = 0; i < 10; i += 2) begin
         press(d[i], d[i+1]);
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL point_roll_%0d_%0d: got %b expected %b", d[i], d[i+1], obsVec, expVec());
         end
         releaseBtn();
      end
   endtask

   task automatic test_dice_err();
      int d[4] = '{0, 5, 7, 2};
      for (int i = 0; i < 4; i += 2) begin
         press(d[i], d[i+1]);
         assertCount++;
         if (obsVec !== expVec() || dice_err !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL dice_err_pulse_%0d_%0d: got %b expected %b", d[i], d[i+1], obsVec, expVec());
         end
         releaseBtn();
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL dice_err_clear: got %b expected %b", obsVec, expVec());
         end
      end
   endtask

   task automatic test_held_button();
      press(3, 3);
      for (int i = 0; i < 10; i++) begin
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL held_cycle_%0d: got %b expected %b", i, obsVec, expVec());
         end
         if (i < 9) holdBtn();
      end
      releaseBtn();
   endtask

   task automatic test_reset_priority();
      doReset();
      press(2, 2);
      releaseBtn();
      x0 = 3'd3;
      x1 = 3'd4;
      reset = 1'b1;
      roll_req = 1'b1;
      @(negedge clock);
      modelReset();
      assertCount++;
      if (obsVec !== 12'b0) begin
         failCount++;
         $display("[TB] FAIL reset_priority: got %b expected %b", obsVec, 12'b0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         holdBtn();
         assertCount++;
         if (obsVec !== 12'b0) begin
            failCount++;
            $display("[TB] FAIL held_through_reset_%0d: got %b expected %b", i, obsVec, 12'b0);
         end
      end
      releaseBtn();
      press(3, 4);
      assertCount++;
      if (obsVec !== expVec()) begin
         failCount++;
         $display("[TB] FAIL roll_after_reset: got %b expected %b", obsVec, expVec());
      end
      releaseBtn();
   endtask

   task automatic test_random();
      int a, b;
      for (int n = 0; n < 200; n++) begin
         a = $urandom_range(1, 6);
         b = $urandom_range(1, 6);
         if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 0 : 7;
         if ($urandom_range(0, 9) == 0) b = ($urandom_range(0, 1) == 1) ? 0 : 7;
         press(a, b);
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL random_%0d_roll_%0d_%0d: got %b expected %b", n, a, b, obsVec, expVec());
         end
         repeat ($urandom_range(0, 2)) begin
            x0 = 3'($urandom_range(0, 7));
            x1 = 3'($urandom_range(0, 7));
            holdBtn();
            assertCount++;
            if (obsVec !== expVec()) begin
               failCount++;
               $display("[TB] FAIL random_%0d_hold: got %b expected %b", n, obsVec, expVec());
            end
         end
         releaseBtn();
         assertCount++;
         if (obsVec !== expVec()) begin
            failCount++;
            $display("[TB] FAIL random_%0d_release: got %b expected %b", n, obsVec, expVec());
         end
`ifdef CRAPS_ROLL_COUNT_EN
         assertCount++;
         if (roll_count !== 8'(mCount)) begin
            failCount++;
            $display("[TB] FAIL random_%0d_count: got %0d expected %0d", n, roll_count, mCount);
         end
`endif
      end
   endtask

`ifdef CRAPS_ROLL_COUNT_EN
   task automatic test_roll_count();
      doReset();
      press(2, 2); releaseBtn();
      press(3, 3); releaseBtn();
      press(5, 5); releaseBtn();
      assertCount++;
      if (roll_count !== 8'd3 || obsVec !== expVec()) begin
         failCount++;
         $display("[TB] FAIL count_three: got %0d/%b expected 3/%b", roll_count, obsVec, expVec());
      end
      repeat (260) begin
         press(5, 5);
         releaseBtn();
      end
      assertCount++;
      if (roll_count !== 8'd255) begin
         failCount++;
         $display("[TB] FAIL count_saturate: got %0d expected 255", roll_count);
      end
      press(2, 2); releaseBtn();
      press(3, 4); releaseBtn();
      assertCount++;
      if (roll_count !== 8'd1 || obsVec !== expVec()) begin
         failCount++;
         $display("[TB] FAIL count_new_game: got %0d/%b expected 1/%b", roll_count, obsVec, expVec());
      end
   endtask
`endif

   // Scenario sequence followed by the summary
   initial begin
      modelReset();
      test_reset();
      test_come_out();
      test_point();
      test_dice_err();
      test_held_button();
      test_reset_priority();
`ifdef CRAPS_ROLL_COUNT_EN
      test_roll_count();
`endif
      doReset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/craps_game_ctrl.md
Name: craps_game_ctrl

Overview:
- Game-rule engine for the craps datapath; the producer side of the win/lose/roll one-hot interface.
- Samples the two die values on a player roll request and applies come-out and point rules.
- Drives win, lose and roll, one-hot, to the downstream result/display encoder.
- Holds the established point and the last rolled sum for display.

Parameters:
- DIE_W, 3, width of each die value input; legal die values are 1..6.
- SUM_W, 4, width of sum and point registers; must hold 12.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high; clears all state and outputs on the next posedge.
- roll_req  input  1  level from the debounced roll button; only a 0->1 transition counts as a roll.
- x0  input  DIE_W  die 0 value, stable when roll_req rises.
- x1  input  DIE_W  die 1 value, stable when roll_req rises.
- win  output  1  registered; game won.
- lose  output  1  registered; game lost.
- roll  output  1  registered; point established, roll again.
- point  output  SUM_W  registered; current point, 0 when no point is set.
- last_sum  output  SUM_W  registered; sum of the last accepted roll.
- dice_err  output  1  registered one-cycle pulse; a roll was rejected for an illegal die value.

Behaviour:
- Reset values: win=0, lose=0, roll=0, point=0, last_sum=0, dice_err=0, state=COME_OUT, edge-detect register=0.
- {win,lose,roll}=000 after reset means "no game in progress". Downstream decodes 000 as the reset code.
- Edge detect: roll_req is registered each cycle. roll_ev = roll_req & ~roll_req_q.
  - A held button produces exactly one event.
  - If roll_req is high at reset release, that is not an event.
- Sum: s = x0 + x1, zero-extended to SUM_W, evaluated in the cycle roll_ev is high.
- Illegal dice: x0 or x1 equal to 0 or greater than 6 on roll_ev.
  - dice_err=1 for one cycle.
  - State, win, lose, roll, point and last_sum are unchanged.
- Latency: outputs reflect an accepted roll on the posedge following the roll_ev cycle (1 cycle).
- All accepted rolls load last_sum<=s.
- States:
  - COME_OUT (no point):
    - s==7 or s==11 -> win=1, lose=0, roll=0; go DONE.
    - s==2, 3 or 12 -> lose=1, win=0, roll=0; go DONE.
    - Otherwise -> point<=s, roll=1, win=0, lose=0; go POINT.
  - POINT:
    - s==point -> win=1, roll=0; go DONE.
    - s==7 -> lose=1, roll=0; go DONE.
    - Otherwise -> stay; roll stays 1; point unchanged.
  - DONE: win or lose is held.
    - Next accepted roll_ev starts a new game: point<=0, then the same roll is evaluated with COME_OUT rules in the same cycle.
    - A new game's first roll is never discarded.
- Invariant: at most one of win/lose/roll is high in any cycle.
- Without roll_ev, all outputs hold; dice_err returns to 0.
- Reset has priority over roll_ev in the same cycle.
- Reset mid-game (POINT or DONE) returns to the reset values on the next posedge.

Optional Feature:
- Macro: CRAPS_ROLL_COUNT_EN.
- Defined:
  - Adds output roll_count [7:0], reset 0.
  - Increments on each accepted roll and saturates at 255.
  - Cleared to 0 when a new game starts from DONE, then counts that roll, so it reads 1.
  - Illegal-dice events do not count.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset, then roll x0=3,x1=4 -> one cycle later win=1, lose=0, roll=0, last_sum=7, point=0.
- Roll 1+1 from reset -> lose=1, last_sum=2. Next roll 5+6 -> new game, win=1, last_sum=11.
- Roll 2+2 -> roll=1, point=4. Then 3+3 -> roll stays 1, point=4. Then 1+3 -> win=1, roll=0.
- Roll 4+5 -> point=9, roll=1. Then 3+4 -> lose=1, roll=0, last_sum=7.
- Roll with x0=0,x1=5 -> dice_err pulses 1 cycle; outputs unchanged. Hold roll_req high 10 cycles with legal dice -> exactly one roll accepted.
- In POINT, assert reset and roll_ev together -> all outputs 0. With CRAPS_ROLL_COUNT_EN defined, roll_count=0 after reset and 3 after three accepted point rolls.
